traffic_phase_sched: RTL and testbench
======================================

TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

Interface
REQ-001 The parameters SHALL be, one per line: name, default, meaning.
  TICK_DIV  1000  clock cycles per timing tick when test=0 (legal >=1)
  GMIN      4     minimum green duration, ticks (legal >=1)
  GMAX      12    maximum farm-road green duration, ticks (legal >=GMIN)
  YLW       3     yellow duration, ticks (legal >=1)
  ARED      1     all-red clearance duration, ticks (legal >=1)
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
  blif_clk_net    in   1  single clock, rising edge
  blif_reset_net  in   1  reset, asynchronous, active-low
  clr             in   1  synchronous clear
  test            in   1  1 = one tick per clock (accelerated timing)
  fm_req          in   1  farm-road vehicle sensor, level
  ped_req         in   1  pedestrian button, sampled per clock
  grn1/ylw1/red1  out  1  highway lamps
  grn2/ylw2/red2  out  1  farm-road lamps
  walk            out  1  pedestrian walk lamp
  phase           out  3  current phase code

Function
REQ-003 The prescaler SHALL count 0..TICK_DIV-1 and assert tick for one cycle at terminal count; with test=1, tick SHALL be asserted every cycle and the prescaler held at 0.
REQ-004 The phases SHALL be HG=0, HY=1, AR1=2, FG=3, FY=4, AR2=5; codes 6-7 SHALL recover to AR2 on the next clock.
REQ-005 The phase timer SHALL increment only on tick, clear on every phase change, and saturate at GMAX (no wrap); width is clog2(GMAX+1).
REQ-006 Transitions SHALL occur only on tick cycles, evaluated against timer+1, so a phase of duration N occupies exactly N ticks.
REQ-007 HG->HY when timer+1>=GMIN and (fm_req or ped_pend); otherwise HG holds indefinitely.
REQ-008 HY->AR1 at YLW ticks; AR1->FG at ARED; FY->AR2 at YLW; AR2->HG at ARED.
REQ-009 FG->FY when timer+1>=GMAX, or timer+1>=GMIN and fm_req=0; fm_req dropping before GMIN SHALL NOT shorten FG.
REQ-010 Lamp outputs and phase SHALL be registered, decoded from the next-state, exactly one lamp per road high: red1 in AR1/FG/FY/AR2, red2 in HG/HY/AR1/AR2.
REQ-011 clr SHALL have priority over tick: next state AR2, timer=0, prescaler=0, ped_pend=0.

Reset
REQ-012 While blif_reset_net=0: phase=5 (AR2), red1=red2=1, all other lamps 0, walk=0, timer=0, prescaler=0, ped_pend=0, applied asynchronously.
REQ-013 Reset deassertion SHALL be synchronized inside the block; the first tick after release counts toward AR2.

Configuration
REQ-014 Macro TRAFFIC_PED_LATCH_EN defined: ped_req=1 on any clock sets ped_pend; ped_pend cleared on entry to FG; walk=1 exactly while in FG.
REQ-015 Macro undefined: ped_req ignored, ped_pend constant 0, walk tied 0.

Structure
REQ-016 Package traffic_pkg SHALL hold the phase enum/encodings, lamp-vector typedef and default timing constants.
REQ-017 The prescaler SHALL be a sub-module tick_prescaler (params TICK_DIV; ports clk, rst_n, clr, test, tick).
REQ-018 Target size 120-400 lines RTL total.

Verification (test=1, default params unless noted)
REQ-019 Reset release, fm_req=0 -> AR2 for 1 cycle, then HG (grn1=1, red2=1) held for 100 cycles.
REQ-020 fm_req=1 held -> HG 4, HY 3, AR1 1, FG 12, FY 3, AR2 1 cycles, repeating.
REQ-021 fm_req 1-cycle pulse in HG after GMIN -> HY next cycle; FG lasts exactly 4 cycles.
REQ-022 clr in FG cycle 5 -> next cycle phase=5, red1=red2=1; HG after 1 more cycle.
REQ-023 TRAFFIC_PED_LATCH_EN, 1-cycle ped_req in HG cycle 2, fm_req=0 -> HY after HG cycle 4; walk=1 for all 4 FG cycles; no second request.
REQ-024 test=0, TICK_DIV=5, fm_req=1 -> HG 20 cycles; blif_reset_net=0 mid-HY -> red1=red2=1 immediately, without a clock edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encodings, lamp vector type and default timing for the phase scheduler.
// Latency: n/a (types, constants and a pure decode function).
// Backpressure: n/a.
package traffic_pkg;

  // Phase codes; 6 and 7 are unused and recover to AR2.
  typedef enum logic [2:0] {
    PH_HG  = 3'd0,
    PH_HY  = 3'd1,
    PH_AR1 = 3'd2,
    PH_FG  = 3'd3,
    PH_FY  = 3'd4,
    PH_AR2 = 3'd5
  } phase_t;

  // One bit per lamp; road 1 is the highway, road 2 the farm road.
  typedef struct packed {
    logic grn1;
    logic ylw1;
    logic red1;
    logic grn2;
    logic ylw2;
    logic red2;
  } lamps_t;

  // Default timing, ticks unless noted.
  localparam int TICK_DIV_DFLT = 1000;  // clock cycles per tick
  localparam int GMIN_DFLT     = 4;
  localparam int GMAX_DFLT     = 12;
  localparam int YLW_DFLT      = 3;
  localparam int ARED_DFLT     = 1;

  // Exactly one lamp per road: red whenever that road is neither green nor yellow.
  function automatic lamps_t lamp_decode(input phase_t ph);
    lamps_t l;
    l      = '0;
    l.grn1 = (ph == PH_HG);
    l.ylw1 = (ph == PH_HY);
    l.red1 = !(l.grn1 || l.ylw1);
    l.grn2 = (ph == PH_FG);
    l.ylw2 = (ph == PH_FY);
    l.red2 = !(l.grn2 || l.ylw2);
    return l;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the clock into timing ticks, one-cycle pulse every TICK_DIV cycles.
// Latency: tick is combinational from the counter; test forces tick every cycle.
// Backpressure: none; free-running, clr restarts the count at 0.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic test,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = test || (cnt == TERM);

  // Count 0..TICK_DIV-1; held at 0 in accelerated mode or on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || test || (cnt == TERM)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: highway/farm-road phase sequencer with registered lamp decode; macro TRAFFIC_PED_LATCH_EN adds pedestrian latch + walk lamp.
// Latency: lamps/phase registered from next-state, change on the edge that ends a tick; reset release takes 2 cycles to synchronise.
// Backpressure: none; sensors are levels sampled every clock, HG holds indefinitely without demand.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DFLT,
  parameter int GMIN     = GMIN_DFLT,
  parameter int GMAX     = GMAX_DFLT,
  parameter int YLW      = YLW_DFLT,
  parameter int ARED     = ARED_DFLT
) (
  input  logic       blif_clk_net,
  input  logic       blif_reset_net,
  input  logic       clr,
  input  logic       test,
  input  logic       fm_req,
  input  logic       ped_req,
  output logic       grn1,
  output logic       ylw1,
  output logic       red1,
  output logic       grn2,
  output logic       ylw2,
  output logic       red2,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int TW = $clog2(GMAX + 1);
  localparam logic [TW-1:0] TMAX = TW'(GMAX);

`ifdef TRAFFIC_PED_LATCH_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic [1:0]    rst_pipe;
  logic          rst_sync;
  logic          tick;
  logic          ped_pend;
  phase_t        phase_q;
  phase_t        phase_nxt;
  logic [TW-1:0] timer_q;
  int            tp1;
  lamps_t        lamps_q;
  logic          walk_q;

  // Assert reset immediately, release it two clocks after the pin rises.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end
  assign rst_sync = rst_pipe[1];

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (blif_clk_net),
    .rst_n (rst_sync),
    .clr   (clr),
    .test  (test),
    .tick  (tick)
  );

  // Transitions compare against timer+1 so a phase of N ticks ends on its Nth tick.
  function automatic phase_t next_phase(input phase_t cur, input logic tk, input int t1,
                                        input logic fm, input logic pend);
    phase_t nxt;
    nxt = cur;
    case (cur)
      PH_HG:   if (tk && (t1 >= GMIN) && (fm || pend)) nxt = PH_HY;
      PH_HY:   if (tk && (t1 >= YLW))  nxt = PH_AR1;
      PH_AR1:  if (tk && (t1 >= ARED)) nxt = PH_FG;
      PH_FG:   if (tk && ((t1 >= GMAX) || ((t1 >= GMIN) && !fm))) nxt = PH_FY;
      PH_FY:   if (tk && (t1 >= YLW))  nxt = PH_AR2;
      PH_AR2:  if (tk && (t1 >= ARED)) nxt = PH_HG;
      default: nxt = PH_AR2;
    endcase
    return nxt;
  endfunction

  assign tp1       = int'(timer_q) + 1;
  assign phase_nxt = clr ? PH_AR2 : next_phase(phase_q, tick, tp1, fm_req, ped_pend);

  // Phase FSM with timer and lamp/walk registers decoded from the next state.
  always_ff @(posedge blif_clk_net or negedge rst_sync) begin
    if (!rst_sync) begin
      phase_q <= PH_AR2;
      timer_q <= '0;
      lamps_q <= lamp_decode(PH_AR2);
      walk_q  <= 1'b0;
    end else begin
      phase_q <= phase_nxt;
      lamps_q <= lamp_decode(phase_nxt);
      walk_q  <= PED_EN && (phase_nxt == PH_FG);
      if (clr || (phase_nxt != phase_q)) begin
        timer_q <= '0;
      end else if (tick && (timer_q != TMAX)) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

`ifdef TRAFFIC_PED_LATCH_EN
  // Latch a button press until FG is entered; a press on the entry clock itself is kept.
  always_ff @(posedge blif_clk_net or negedge rst_sync) begin
    if (!rst_sync) begin
      ped_pend <= 1'b0;
    end else if (clr) begin
      ped_pend <= 1'b0;
    end else if (ped_req) begin
      ped_pend <= 1'b1;
    end else if ((phase_nxt == PH_FG) && (phase_q != PH_FG)) begin
      ped_pend <= 1'b0;
    end
  end
`else
  logic ped_unused;
  assign ped_unused = ped_req;
  assign ped_pend   = 1'b0;
`endif

  assign grn1  = lamps_q.grn1;
  assign ylw1  = lamps_q.ylw1;
  assign red1  = lamps_q.red1;
  assign grn2  = lamps_q.grn2;
  assign ylw2  = lamps_q.ylw2;
  assign red2  = lamps_q.red2;
  assign walk  = walk_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb_traffic_phase_sched: directed scenarios plus randomized run against a tick/phase-duration model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_traffic_phase_sched;

  localparam int TICK_DIV = 5;
  localparam int GMIN     = 4;
  localparam int GMAX     = 12;
  localparam int YLW      = 3;
  localparam int ARED     = 1;

`ifdef TRAFFIC_PED_LATCH_EN
  localparam bit PED_BUILD = 1'b1;
`else
  localparam bit PED_BUILD = 1'b0;
`endif

  // {phase, grn1, ylw1, red1, grn2, ylw2, red2, walk} while in reset / AR2
  localparam logic [9:0] RST_VEC = {3'd5, 6'b001001, 1'b0};

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       clr     = 1'b0;
  logic       test    = 1'b1;
  logic       fm_req  = 1'b0;
  logic       ped_req = 1'b0;
  logic       grn1, ylw1, red1, grn2, ylw2, red2, walk;
  logic [2:0] phase;
  logic [9:0] dv;

  int tests = 0;
  int fails = 0;

  // Reference model: phase index 0..5 in ring order, ticks spent in it, cycles since last tick.
  int m_ph   = 5;
  int m_el   = 0;
  int m_div  = 0;
  int m_sync = 2;
  bit m_pend = 1'b0;

  always #5 clk = ~clk;

  traffic_phase_sched #(
    .TICK_DIV (TICK_DIV),
    .GMIN     (GMIN),
    .GMAX     (GMAX),
    .YLW      (YLW),
    .ARED     (ARED)
  ) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .clr            (clr),
    .test           (test),
    .fm_req         (fm_req),
    .ped_req        (ped_req),
    .grn1           (grn1),
    .ylw1           (ylw1),
    .red1           (red1),
    .grn2           (grn2),
    .ylw2           (ylw2),
    .red2           (red2),
    .walk           (walk),
    .phase          (phase)
  );

  assign dv = {phase, grn1, ylw1, red1, grn2, ylw2, red2, walk};

  function automatic logic [9:0] exp_vec(input int ph);
    logic g1, y1, g2, y2, w;
    g1 = (ph == 0);
    y1 = (ph == 1);
    g2 = (ph == 3);
    y2 = (ph == 4);
    w  = PED_BUILD && (ph == 3);
    return {3'(ph), g1, y1, !(g1 || y1), g2, y2, !(g2 || y2), w};
  endfunction

  function automatic int fixed_dur(input int ph);
    return ((ph == 1) || (ph == 4)) ? YLW : ARED;
  endfunction

  task automatic model_reset();
    m_ph   = 5;
    m_el   = 0;
    m_div  = 0;
    m_pend = 1'b0;
    m_sync = 2;
  endtask

  // One clock edge of the reference model with the inputs present during the cycle.
  task automatic model_edge(input bit c, input bit t, input bit f, input bit p);
    bit tk, done;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_sync > 0) begin
      m_sync--;
      return;
    end
    if (c) begin
      m_ph   = 5;
      m_el   = 0;
      m_div  = 0;
      m_pend = 1'b0;
      return;
    end
    tk    = t || (m_div == TICK_DIV - 1);
    m_div = tk ? 0 : m_div + 1;
    done  = 1'b0;
    if (tk) begin
      m_el++;
      if (m_ph == 0)      done = (m_el >= GMIN) && (f || m_pend);
      else if (m_ph == 3) done = (m_el >= GMAX) || ((m_el >= GMIN) && !f);
      else                done = (m_el >= fixed_dur(m_ph));
      if (done) begin
        m_ph = (m_ph + 1) % 6;
        m_el = 0;
        if (m_ph == 3) m_pend = 1'b0;
      end
    end
    if (PED_BUILD && p) m_pend = 1'b1;
  endtask

  task automatic step(input bit c, input bit t, input bit f, input bit p);
    clr = c; test = t; fm_req = f; ped_req = p;
    @(posedge clk);
    model_edge(c, t, f, p);
    #1;
  endtask

  task automatic test_reset();
    int n5, held;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    tests++;
    if (dv !== RST_VEC) begin fails++; $display("FAIL reset_state: got %b want %b", dv, RST_VEC); end
    rst_n = 1'b1;
    n5 = 0;
    step(0, 1, 0, 0);
    while ((phase == 3'd5) && (n5 < 10)) begin n5++; step(0, 1, 0, 0); end
    // one synchroniser cycle plus the single AR2 tick
    tests++;
    if (n5 != 2) begin fails++; $display("FAIL release_ar2_cycles: got %0d want 2", n5); end
    held = 0;
    for (int i = 0; i < 100; i++) begin
      if (dv === exp_vec(0)) held++;
      step(0, 1, 0, 0);
    end
    tests++;
    if (held != 100) begin fails++; $display("FAIL hg_idle_hold: got %0d want 100", held); end
  endtask

  task automatic test_fm_hold();
    logic [2:0] ph [60];
    int exp_run [6] = '{4, 3, 1, 12, 3, 1};
    int i, j, runs, pi, want, nx;
    for (int k = 0; k < 60; k++) begin step(0, 1, 1, 0); ph[k] = phase; end
    runs = 0;
    i = 1;
    while ((i < 60) && (ph[i] == ph[0])) i++;
    while (i < 60) begin
      j = i;
      while ((j < 60) && (ph[j] == ph[i])) j++;
      if (j < 60) begin
        runs++;
        pi   = int'(ph[i]);
        want = (pi < 6) ? exp_run[pi] : -1;
        nx   = (pi + 1) % 6;
        tests++;
        if ((j - i) != want) begin fails++; $display("FAIL fm_run_len phase %0d: got %0d want %0d", pi, j - i, want); end
        tests++;
        if (int'(ph[j]) != nx) begin fails++; $display("FAIL fm_run_order after %0d: got %0d want %0d", pi, ph[j], nx); end
      end
      i = j;
    end
    tests++;
    if (runs < 6) begin fails++; $display("FAIL fm_run_count: got %0d want >=6", runs); end
  endtask

  task automatic test_pulse();
    int n;
    n = 0;
    while ((phase != 3'd0) && (n < 60)) begin n++; step(0, 1, 0, 0); end
    tests++;
    if (phase !== 3'd0) begin fails++; $display("FAIL pulse_reach_hg: got %0d want 0", phase); end
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    tests++;
    if (phase !== 3'd0) begin fails++; $display("FAIL pulse_hg_wait: got %0d want 0", phase); end
    step(0, 1, 1, 0);
    tests++;
    if (dv !== exp_vec(1)) begin fails++; $display("FAIL pulse_to_hy: got %b want %b", dv, exp_vec(1)); end
    n = 0;
    while ((phase != 3'd3) && (n < 20)) begin n++; step(0, 1, 0, 0); end
    n = 0;
    while ((phase == 3'd3) && (n < 20)) begin n++; step(0, 1, 0, 0); end
    tests++;
    if (n != GMIN) begin fails++; $display("FAIL pulse_fg_len: got %0d want %0d", n, GMIN); end
    tests++;
    if (phase !== 3'd4) begin fails++; $display("FAIL pulse_fg_exit: got %0d want 4", phase); end
  endtask

  task automatic test_clr();
    int n;
    n = 0;
    while ((phase != 3'd3) && (n < 60)) begin n++; step(0, 1, 1, 0); end
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
    tests++;
    if (phase !== 3'd3) begin fails++; $display("FAIL clr_fg_cycle5: got %0d want 3", phase); end
    step(1, 1, 1, 0);
    tests++;
    if (dv !== RST_VEC) begin fails++; $display("FAIL clr_to_ar2: got %b want %b", dv, RST_VEC); end
    step(0, 1, 0, 0);
    tests++;
    if (dv !== exp_vec(0)) begin fails++; $display("FAIL clr_then_hg: got %b want %b", dv, exp_vec(0)); end
  endtask

  task automatic test_ped();
    int n, held;
    step(0, 1, 0, 0);          // now HG cycle 2
    step(0, 1, 0, 1);          // button held during HG cycle 2
    step(0, 1, 0, 0);          // now HG cycle 4
    tests++;
    if (phase !== 3'd0) begin fails++; $display("FAIL ped_hg_cycle4: got %0d want 0", phase); end
    step(0, 1, 0, 0);
`ifdef TRAFFIC_PED_LATCH_EN
    begin
      int nfg, nw;
      tests++;
      if (dv !== exp_vec(1)) begin fails++; $display("FAIL ped_to_hy: got %b want %b", dv, exp_vec(1)); end
      n = 0;
      while ((phase != 3'd3) && (n < 10)) begin n++; step(0, 1, 0, 0); end
      nfg = 0;
      nw  = 0;
      while ((phase == 3'd3) && (nfg < 20)) begin
        nfg++;
        if (walk === 1'b1) nw++;
        step(0, 1, 0, 0);
      end
      tests++;
      if (nfg != 4) begin fails++; $display("FAIL ped_fg_len: got %0d want 4", nfg); end
      tests++;
      if (nw != 4) begin fails++; $display("FAIL ped_walk_cycles: got %0d want 4", nw); end
      n = 0;
      while ((phase != 3'd0) && (n < 20)) begin n++; step(0, 1, 0, 0); end
    end
`else
    tests++;
    if (dv !== exp_vec(0)) begin fails++; $display("FAIL ped_ignored: got %b want %b", dv, exp_vec(0)); end
`endif
    held = 0;
    for (int i = 0; i < 30; i++) begin
      if (dv === exp_vec(0)) held++;
      step(0, 1, 0, 0);
    end
    tests++;
    if (held != 30) begin fails++; $display("FAIL ped_no_repeat: got %0d want 30", held); end
  endtask

  task automatic test_random();
    bit tv, fv, cv, pv;
    rst_n = 1'b0;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    rst_n = 1'b1;
    tv = 1'b1;
    fv = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if ((k % 64) == 0) tv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) fv = !fv;
      cv = ($urandom_range(0, 59) == 0);
      pv = ($urandom_range(0, 24) == 0);
      step(cv, tv, fv, pv);
      tests++;
      if (dv !== exp_vec(m_ph)) begin
        fails++;
        $display("FAIL random cycle %0d: got %b want %b", k, dv, exp_vec(m_ph));
      end
    end
  endtask

  task automatic test_slow_tick();
    int n;
    rst_n = 1'b0;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    rst_n = 1'b1;
    n = 0;
    while ((phase != 3'd0) && (n < 40)) begin n++; step(0, 0, 1, 0); end
    tests++;
    if (phase !== 3'd0) begin fails++; $display("FAIL slow_reach_hg: got %0d want 0", phase); end
    n = 0;
    while ((phase == 3'd0) && (n < 100)) begin n++; step(0, 0, 1, 0); end
    tests++;
    if (n != GMIN * TICK_DIV) begin fails++; $display("FAIL slow_hg_len: got %0d want %0d", n, GMIN * TICK_DIV); end
    tests++;
    if (phase !== 3'd1) begin fails++; $display("FAIL slow_hy: got %0d want 1", phase); end
    step(0, 0, 1, 0);
    rst_n = 1'b0;
    #2;
    tests++;
    if (dv !== RST_VEC) begin fails++; $display("FAIL async_reset: got %b want %b", dv, RST_VEC); end
    step(0, 0, 1, 0);
    tests++;
    if (dv !== RST_VEC) begin fails++; $display("FAIL reset_hold: got %b want %b", dv, RST_VEC); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fm_hold();
    test_pulse();
    test_clr();
    test_ped();
    test_random();
    test_slow_tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
